reaction_timer_multi: RTL and testbench
=======================================

REACTION_TIMER_MULTI -- requirements
Module: reaction_timer_multi

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2: number of hit buttons/channels (1..8).
REQ-002 SHALL have parameter SCORE_W, default 13: score width in ms ticks; SCORE_MAX = 2^SCORE_W-1.
REQ-003 SHALL have parameter NUM_TRIALS, default 4: trials per game; power of two, 1..16.
REQ-004 SHALL have parameter TICK_DIV, default 50000: Clock cycles per 1 ms tick.
REQ-005 SHALL have parameter MIN_DELAY, default 1000, and DELAY_MASK, default 2047: random delay = MIN_DELAY + (LFSR & DELAY_MASK) ticks.
REQ-006 SHALL have port Clock, input, 1: sole clock; all state rising-edge.
REQ-007 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1: one-cycle pulse, debounced and active-high upstream.
REQ-009 SHALL have port hit, input, NUM_PLAYERS: one-cycle pulses, one per player.
REQ-010 SHALL have port rd_sel, input, clog2(NUM_PLAYERS): player select for read-back.
REQ-011 SHALL have outputs green_led 1, red_led 1, state 3, trial_idx clog2(NUM_TRIALS)+1, winner clog2(NUM_PLAYERS), foul NUM_PLAYERS.
REQ-012 SHALL have outputs rd_last SCORE_W, rd_best SCORE_W, rd_avg SCORE_W: selected player's last, best, average score; combinational from registers.

Function
REQ-013 FSM states SHALL be IDLE=0, DELAY=1, ARMED=2, RESULT=3, DONE=4; state output = encoding.
REQ-014 Prescaler SHALL emit a one-Clock tick enable every TICK_DIV cycles, free-running; no derived clocks.
REQ-015 IDLE + start -> DELAY; trial_idx<=0, delay counter loaded from 16-bit LFSR (x^16+x^14+x^13+x^11+1, advances every Clock).
REQ-016 DELAY SHALL decrement on tick; at zero -> ARMED next cycle, green_led=1, score counter cleared.
REQ-017 hit[p] during DELAY SHALL set foul[p], red_led=1; player p's trial score = SCORE_MAX; p's later hits this trial ignored.
REQ-018 ARMED: score counter increments per tick, saturating at SCORE_MAX; first hit[p] at cycle n latches counter value into last[p] at n+1.
REQ-019 ARMED -> RESULT when every player has hit or fouled, or counter reaches SCORE_MAX (unhit players scored SCORE_MAX).
REQ-020 Simultaneous hits SHALL record identical scores; winner = lowest index with minimum trial score, updated on RESULT entry.
REQ-021 On RESULT entry best[p] <= min(best[p], last[p]); green_led=0.
REQ-022 RESULT + start -> DELAY (trial_idx+1, foul and red_led cleared) if trial_idx < NUM_TRIALS-1, else DONE.
REQ-023 DONE holds all scores; start -> IDLE-equivalent restart (scores cleared, DELAY entered).
REQ-024 start in DELAY or ARMED SHALL be ignored; hit in IDLE, RESULT, DONE ignored.

Reset
REQ-025 Reset SHALL force state=IDLE, green_led=0, red_led=0, foul=0, trial_idx=0, winner=0, last=0, best=SCORE_MAX, sums=0, prescaler=0, LFSR=16'hACE1, at any point mid-game.
REQ-026 Reset SHALL dominate start and hit in the same cycle.

Configuration
REQ-027 Macro REACTION_TIMER_AVG_EN defined: per-player (SCORE_W+4)-bit running sum accumulated on RESULT entry; rd_avg = sum >> log2(NUM_TRIALS), valid in DONE.
REQ-028 Macro undefined: no sum registers; rd_avg tied to 0.

Structure
REQ-029 Shared package SHALL hold FSM state enum, LFSR polynomial/seed constants, and SCORE_W-related width function.
REQ-030 Prescaler SHALL be sub-module rt_tick_gen (parameter TICK_DIV, ports Clock, Reset, tick); remainder in one module.

Verification
REQ-031 TICK_DIV=4, NUM_PLAYERS=2: start, hit[0] 40 Clocks after green, hit[1] 80 -> last=10,20; winner=0.
REQ-032 hit[1] during DELAY -> foul=2'b10, red_led=1, last[1]=SCORE_MAX, winner=0.
REQ-033 hit=2'b11 same cycle -> last[0]=last[1], winner=0.
REQ-034 SCORE_W=4, no hits -> counter saturates at 15, RESULT entered, both last=15.
REQ-035 4 trials, player 0 scores 8,12,4,16 -> best=4, rd_avg=10 (AVG_EN), 0 (undefined); state=DONE.
REQ-036 Reset asserted in ARMED -> next cycle state=0, green_led=0, best=SCORE_MAX.

Source files
------------

// File: rtl/reaction_timer_multi_pkg.sv
// +--------------------------------------------------------------------+
// | reaction_timer_multi_pkg : shared FSM encoding, LFSR constants and  |
// | width helpers for the multi-player reaction timer.                  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package reaction_timer_multi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DELAY  = 3'd1,
    ST_ARMED  = 3'd2,
    ST_RESULT = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form (taps on bits 15,13,12,10)
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int sum_w(input int score_w);
    return score_w + 4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reaction_timer_multi_tick_gen.sv
// +--------------------------------------------------------------------+
// | rt_tick_gen : free-running prescaler, one-cycle tick every TICK_DIV |
// | clocks.                                                             |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module rt_tick_gen
  import reaction_timer_multi_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic Clock,
  input  logic Reset,
  output logic tick
);

  localparam int CW = idx_w(TICK_DIV);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (cnt_q == CW'(TICK_DIV - 1)) begin
      cnt_q <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CW'(1);
      tick  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reaction_timer_multi.sv
// +--------------------------------------------------------------------+
// | reaction_timer_multi : multi-player reaction timer with per-player  |
// | last/best scores; optional running average via REACTION_TIMER_AVG_EN|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module reaction_timer_multi
  import reaction_timer_multi_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 13,
  parameter int NUM_TRIALS  = 4,
  parameter int TICK_DIV    = 50000,
  parameter int MIN_DELAY   = 1000,
  parameter int DELAY_MASK  = 2047
) (
  input  logic                              Clock,
  input  logic                              Reset,
  input  logic                              start,
  input  logic [NUM_PLAYERS-1:0]            hit,
  input  logic [idx_w(NUM_PLAYERS)-1:0]     rd_sel,
  output logic                              green_led,
  output logic                              red_led,
  output logic [2:0]                        state,
  output logic [$clog2(NUM_TRIALS):0]       trial_idx,
  output logic [idx_w(NUM_PLAYERS)-1:0]     winner,
  output logic [NUM_PLAYERS-1:0]            foul,
  output logic [SCORE_W-1:0]                rd_last,
  output logic [SCORE_W-1:0]                rd_best,
  output logic [SCORE_W-1:0]                rd_avg
);

  localparam int PW = idx_w(NUM_PLAYERS);
  localparam int TW = $clog2(NUM_TRIALS) + 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_e                 state_q;
  logic                   green_q, red_q, tick;
  logic [NUM_PLAYERS-1:0] foul_q, done_q;
  logic [TW-1:0]          trial_q;
  logic [PW-1:0]          winner_q, winner_d;
  logic [SCORE_W-1:0]     last_q  [NUM_PLAYERS];
  logic [SCORE_W-1:0]     best_q  [NUM_PLAYERS];
  logic [SCORE_W-1:0]     score_d [NUM_PLAYERS];
  logic [SCORE_W-1:0]     cnt_q, min_d;
  logic [31:0]            delay_q, delay_d;
  logic [15:0]            lfsr_q;
  logic                   new_game_d, result_entry_d, sel_ok;

  rt_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .Clock (Clock),
    .Reset (Reset),
    .tick  (tick)
  );

  // Players that never hit this trial are charged the saturated score.
  always_comb begin
    new_game_d     = start && (state_q == ST_IDLE || state_q == ST_DONE);
    result_entry_d = (state_q == ST_ARMED) && ((&done_q) || cnt_q == SCORE_MAX);
    delay_d        = 32'(MIN_DELAY) + 32'(lfsr_q & 16'(DELAY_MASK));
    for (int p = 0; p < NUM_PLAYERS; p++)
      score_d[p] = done_q[p] ? last_q[p] : SCORE_MAX;
    winner_d = '0;
    min_d    = score_d[0];
    for (int p = 1; p < NUM_PLAYERS; p++) begin
      if (score_d[p] < min_d) begin
        min_d    = score_d[p];
        winner_d = PW'(p);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      green_q  <= 1'b0;
      red_q    <= 1'b0;
      foul_q   <= '0;
      done_q   <= '0;
      trial_q  <= '0;
      winner_q <= '0;
      cnt_q    <= '0;
      delay_q  <= '0;
      lfsr_q   <= LFSR_SEED;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        last_q[p] <= '0;
        best_q[p] <= SCORE_MAX;
      end
    end else begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (new_game_d) begin
            state_q <= ST_DELAY;
            delay_q <= delay_d;
            trial_q <= '0;
            foul_q  <= '0;
            done_q  <= '0;
            red_q   <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
              last_q[p] <= '0;
              best_q[p] <= SCORE_MAX;
            end
          end
        end
        ST_DELAY: begin
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (hit[p] && !done_q[p]) begin
              foul_q[p] <= 1'b1;
              done_q[p] <= 1'b1;
              last_q[p] <= SCORE_MAX;
              red_q     <= 1'b1;
            end
          end
          if (delay_q == '0) begin
            state_q <= ST_ARMED;
            green_q <= 1'b1;
            cnt_q   <= '0;
          end else if (tick) begin
            delay_q <= delay_q - 32'd1;
          end
        end
        ST_ARMED: begin
          if (result_entry_d) begin
            state_q  <= ST_RESULT;
            green_q  <= 1'b0;
            winner_q <= winner_d;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
              last_q[p] <= score_d[p];
              best_q[p] <= (score_d[p] < best_q[p]) ? score_d[p] : best_q[p];
            end
          end else begin
            if (tick && cnt_q != SCORE_MAX)
              cnt_q <= cnt_q + SCORE_W'(1);
            for (int p = 0; p < NUM_PLAYERS; p++) begin
              if (hit[p] && !done_q[p]) begin
                last_q[p] <= cnt_q;
                done_q[p] <= 1'b1;
              end
            end
          end
        end
        ST_RESULT: begin
          if (start) begin
            trial_q <= trial_q + TW'(1);
            if (trial_q < TW'(NUM_TRIALS - 1)) begin
              state_q <= ST_DELAY;
              delay_q <= delay_d;
              foul_q  <= '0;
              done_q  <= '0;
              red_q   <= 1'b0;
            end else begin
              state_q <= ST_DONE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sel_ok    = 32'(rd_sel) < NUM_PLAYERS;
  assign state     = state_q;
  assign green_led = green_q;
  assign red_led   = red_q;
  assign foul      = foul_q;
  assign trial_idx = trial_q;
  assign winner    = winner_q;
  assign rd_last   = sel_ok ? last_q[rd_sel] : '0;
  assign rd_best   = sel_ok ? best_q[rd_sel] : '0;

`ifdef REACTION_TIMER_AVG_EN
  localparam int SW = sum_w(SCORE_W);

  logic [SW-1:0] sum_q [NUM_PLAYERS];

  always_ff @(posedge Clock) begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (Reset || new_game_d)
        sum_q[p] <= '0;
      else if (result_entry_d)
        sum_q[p] <= sum_q[p] + SW'(score_d[p]);
    end
  end

  assign rd_avg = sel_ok ? SCORE_W'(sum_q[rd_sel] >> $clog2(NUM_TRIALS)) : '0;
`else
  assign rd_avg = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reaction_timer_multi.sv
// +--------------------------------------------------------------------+
// | tb_reaction_timer_multi : directed self-checking bench for          |
// | reaction_timer_multi (main instance plus a 4-bit-score instance).   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_reaction_timer_multi;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0, start_b = 1'b0;
  logic [1:0]  hit = 2'b00, hit_b = 2'b00;
  logic        rd_sel = 1'b0, rd_sel_b = 1'b0;

  logic        green_led, red_led, winner, green_b, red_b, winner_b;
  logic [2:0]  state, state_b, trial_idx, trial_b;
  logic [1:0]  foul, foul_b;
  logic [12:0] rd_last, rd_best, rd_avg;
  logic [3:0]  last_b, best_b, avg_b;

  int checks   = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  reaction_timer_multi #(
    .NUM_PLAYERS(2), .SCORE_W(13), .NUM_TRIALS(4),
    .TICK_DIV(4), .MIN_DELAY(2), .DELAY_MASK(3)
  ) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .hit(hit), .rd_sel(rd_sel),
    .green_led(green_led), .red_led(red_led), .state(state),
    .trial_idx(trial_idx), .winner(winner), .foul(foul),
    .rd_last(rd_last), .rd_best(rd_best), .rd_avg(rd_avg)
  );

  reaction_timer_multi #(
    .NUM_PLAYERS(2), .SCORE_W(4), .NUM_TRIALS(4),
    .TICK_DIV(4), .MIN_DELAY(2), .DELAY_MASK(3)
  ) dut_b (
    .Clock(Clock), .Reset(Reset), .start(start_b), .hit(hit_b), .rd_sel(rd_sel_b),
    .green_led(green_b), .red_led(red_b), .state(state_b),
    .trial_idx(trial_b), .winner(winner_b), .foul(foul_b),
    .rd_last(last_b), .rd_best(best_b), .rd_avg(avg_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic play_hit(input logic [1:0] h, input int n);
    repeat (n) step();
    hit = h;
    step();
    hit = 2'b00;
  endtask

  task automatic wait_green(input string tag);
    int n = 0;
    while (green_led !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    check(tag, 32'(green_led), 32'd1);
  endtask

  task automatic chk_player(input string tag, input logic p,
                            input logic [31:0] exp_last, input logic [31:0] exp_best);
    rd_sel = p;
    #1;
    check({tag, "_last"}, 32'(rd_last), exp_last);
    check({tag, "_best"}, 32'(rd_best), exp_best);
  endtask

  initial begin
    int n;
    int n_tab[4];
    logic [31:0] exp_avg;
    n_tab = '{32, 48, 16, 64};
`ifdef REACTION_TIMER_AVG_EN
    exp_avg = 32'd10;
`else
    exp_avg = 32'd0;
`endif

    repeat (3) step();
    Reset = 1'b0;
    check("rst_state", 32'(state), 32'd0);
    check("rst_green", 32'(green_led), 32'd0);
    check("rst_red", 32'(red_led), 32'd0);
    check("rst_foul", 32'(foul), 32'd0);
    check("rst_trial", 32'(trial_idx), 32'd0);
    check("rst_winner", 32'(winner), 32'd0);
    chk_player("rst_p0", 1'b0, 32'd0, 32'd8191);
    check("rst_avg", 32'(rd_avg), 32'd0);

    // Saturation on the 4-bit instance: nobody hits.
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    n = 0;
    while (state_b !== 3'd3 && n < 400) begin
      step();
      n++;
    end
    check("sat_state", 32'(state_b), 32'd3);
    check("sat_green", 32'(green_b), 32'd0);
    rd_sel_b = 1'b0;
    #1;
    check("sat_last0", 32'(last_b), 32'd15);
    rd_sel_b = 1'b1;
    #1;
    check("sat_last1", 32'(last_b), 32'd15);

    // Game 1, trial 0: p0 after 40 clocks, p1 after 80.
    pulse_start();
    check("t0_state_delay", 32'(state), 32'd1);
    check("t0_trial", 32'(trial_idx), 32'd0);
    wait_green("t0_green");
    check("t0_state_armed", 32'(state), 32'd2);
    play_hit(2'b01, 40);
    chk_player("t0_p0_mid", 1'b0, 32'd10, 32'd8191);
    play_hit(2'b10, 39);
    step();
    check("t0_state_result", 32'(state), 32'd3);
    check("t0_green_off", 32'(green_led), 32'd0);
    check("t0_winner", 32'(winner), 32'd0);
    chk_player("t0_p0", 1'b0, 32'd10, 32'd10);
    chk_player("t0_p1", 1'b1, 32'd20, 32'd20);

    // Trial 1: p1 fouls in DELAY, p0 hits after 20.
    pulse_start();
    check("t1_trial", 32'(trial_idx), 32'd1);
    hit = 2'b10;
    step();
    hit = 2'b00;
    check("t1_foul", 32'(foul), 32'd2);
    check("t1_red", 32'(red_led), 32'd1);
    chk_player("t1_p1_foul", 1'b1, 32'd8191, 32'd20);
    wait_green("t1_green");
    check("t1_foul_hold", 32'(foul), 32'd2);
    play_hit(2'b01, 20);
    step();
    check("t1_state_result", 32'(state), 32'd3);
    check("t1_winner", 32'(winner), 32'd0);
    chk_player("t1_p0", 1'b0, 32'd5, 32'd5);

    // Trial 2: start in ARMED ignored, simultaneous hits after 24.
    pulse_start();
    check("t2_foul_clr", 32'(foul), 32'd0);
    check("t2_red_clr", 32'(red_led), 32'd0);
    wait_green("t2_green");
    pulse_start();
    check("t2_start_ignored", 32'(state), 32'd2);
    play_hit(2'b11, 23);
    step();
    check("t2_state_result", 32'(state), 32'd3);
    check("t2_winner", 32'(winner), 32'd0);
    chk_player("t2_p0", 1'b0, 32'd6, 32'd5);
    chk_player("t2_p1", 1'b1, 32'd6, 32'd6);

    // Trial 3 then DONE.
    pulse_start();
    check("t3_trial", 32'(trial_idx), 32'd3);
    wait_green("t3_green");
    play_hit(2'b11, 8);
    step();
    check("t3_state_result", 32'(state), 32'd3);
    pulse_start();
    check("g1_done", 32'(state), 32'd4);

    // Game 2: restart from DONE, p0 scores 8,12,4,16.
    pulse_start();
    check("g2_state", 32'(state), 32'd1);
    check("g2_trial", 32'(trial_idx), 32'd0);
    chk_player("g2_clr", 1'b0, 32'd0, 32'd8191);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) pulse_start();
      wait_green("g2_green");
      if (i < 3) begin
        play_hit(2'b11, n_tab[i]);
      end else begin
        play_hit(2'b10, 40);
        play_hit(2'b01, 23);
      end
      step();
      check("g2_result", 32'(state), 32'd3);
      rd_sel = 1'b0;
      #1;
      check("g2_last0", 32'(rd_last), 32'(n_tab[i] / 4));
    end
    check("g2_winner_p1", 32'(winner), 32'd1);
    pulse_start();
    check("g2_done", 32'(state), 32'd4);
    chk_player("g2_p0", 1'b0, 32'd16, 32'd4);
    check("g2_avg0", 32'(rd_avg), exp_avg);
    chk_player("g2_p1", 1'b1, 32'd10, 32'd4);

    // Reset in ARMED, dominating start and hit in the same cycle.
    pulse_start();
    wait_green("rst_arm_green");
    Reset = 1'b1;
    start = 1'b1;
    hit   = 2'b11;
    step();
    Reset = 1'b0;
    start = 1'b0;
    hit   = 2'b00;
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_green", 32'(green_led), 32'd0);
    check("mid_rst_trial", 32'(trial_idx), 32'd0);
    check("mid_rst_foul", 32'(foul), 32'd0);
    chk_player("mid_rst_p0", 1'b0, 32'd0, 32'd8191);
    chk_player("mid_rst_p1", 1'b1, 32'd0, 32'd8191);
    check("mid_rst_b_state", 32'(state_b), 32'd0);
    repeat (3) step();
    check("mid_rst_idle_hold", 32'(state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
